matvec_mac_engine: RTL

Streaming signed matrix-vector multiply engine computing y = M·x for a ROWS×COLS matrix and a COLS-element vector. Operands arrive as a single valid/ready element stream into internal register-file memories, a single MAC lane accumulates each row, and results leave one row at a time on a valid/ready output stream. It supersedes the fixed 3×3 MAC datapath with a self-sequencing FSM, configurable dimensions, back-pressure on both sides and optional matrix reuse.

---
 rtl/mvm_pkg.sv | 31 +++
 rtl/matvec_mac_engine_if.sv | 16 +
 rtl/mvm_mac_lane.sv | 53 +++++
 rtl/matvec_mac_engine.sv | 113 +++++++++++
 4 files changed

// File: rtl/mvm_pkg.sv
// mvm_pkg: shared types, default dimensions and saturating add for matvec_mac_engine.
package mvm_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_ROWS      = 3;
    localparam int DEF_COLS      = 3;
    localparam int DEF_ACC_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_M,
        LOAD_X,
        COMPUTE,
        DRAIN,
        OUTPUT
    } state_t;

    // Operands are sign-extended from a w-bit accumulator, so the 64-bit sum never wraps.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int w,
                                                   output logic sat);
        logic signed [63:0] s, hi, lo;
        s   = a + b;
        hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo  = -hi - 64'sd1;
        sat = (s > hi) || (s < lo);
        return (s > hi) ? hi : (s < lo) ? lo : s;
    endfunction

endpackage

// File: rtl/matvec_mac_engine_if.sv
// matvec_mac_engine_if: element input stream, result output stream and job-mode flag.
interface matvec_mac_engine_if #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16
);
    logic [WIDTH-1:0]     s_data;
    logic                 s_valid;
    logic                 s_ready;
    logic                 keep_m;
    logic [ACC_WIDTH-1:0] m_data;
    logic                 m_valid;
    logic                 m_ready;

    modport master (output s_data, s_valid, keep_m, m_ready, input s_ready, m_data, m_valid);
    modport slave  (input s_data, s_valid, keep_m, m_ready, output s_ready, m_data, m_valid);
endinterface

// File: rtl/mvm_mac_lane.sv
// mvm_mac_lane: registered signed multiply feeding a clearable accumulator.
// MVM_SAT_EN selects clamping adds with a sticky overflow flag; otherwise adds wrap.
module mvm_mac_lane
    import mvm_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en_i,
    input  logic                        first_i,
    input  logic                        clr_ovf_i,
    input  logic signed [WIDTH-1:0]     a_i,
    input  logic signed [WIDTH-1:0]     b_i,
    output logic signed [ACC_WIDTH-1:0] acc_o,
    output logic                        ovf_o
);
    logic signed [2*WIDTH-1:0]   prod_q;
    logic                        v_q, first_q, ovf_q, sat;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d, base, addend;

    always_comb begin
        base   = first_q ? '0 : acc_q;
        addend = ACC_WIDTH'(prod_q);
        sat    = 1'b0;
`ifdef MVM_SAT_EN
        acc_d  = ACC_WIDTH'(sat_add(64'(base), 64'(addend), ACC_WIDTH, sat));
`else
        acc_d  = base + addend;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prod_q  <= '0;
            v_q     <= 1'b0;
            first_q <= 1'b0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            prod_q  <= (2*WIDTH)'(a_i) * (2*WIDTH)'(b_i);
            v_q     <= en_i;
            first_q <= first_i;
            if (v_q) acc_q <= acc_d;
            if (clr_ovf_i) ovf_q <= 1'b0;
            else if (v_q && sat) ovf_q <= 1'b1;
        end
    end

    assign acc_o = acc_q;
    assign ovf_o = ovf_q;
endmodule

// File: rtl/matvec_mac_engine.sv
// matvec_mac_engine: streaming signed y = M*x engine with register-file operands and one MAC lane.
// MVM_SAT_EN enables saturating accumulation and the sticky ovf flag.
module matvec_mac_engine
    import mvm_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ROWS      = DEF_ROWS,
    parameter int COLS      = DEF_COLS,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    matvec_mac_engine_if.slave  bus,
    output logic                ovf,
    output logic                busy
);
    localparam int MN = ROWS * COLS;
    localparam int CW = (MN > 1) ? $clog2(MN) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d, wa, m_addr;
    logic [RW-1:0]   row_q, row_d;
    logic            mv_q, mv_d;
    logic            hs, keep_eff, wr_m, wr_x, start, en, first;
    logic [WIDTH-1:0] m_mem [2**CW];
    logic [WIDTH-1:0] x_mem [2**CW];
    logic signed [ACC_WIDTH-1:0] acc;

    assign hs       = bus.s_valid && bus.s_ready;
    assign keep_eff = bus.keep_m && mv_q;
    assign wa       = (state_q == IDLE) ? '0 : cnt_q;
    assign wr_m     = hs && (state_q == LOAD_M || (state_q == IDLE && !keep_eff));
    assign wr_x     = hs && (state_q == LOAD_X || (state_q == IDLE && keep_eff));
    assign m_addr   = CW'(row_q * COLS) + cnt_q;

    always_ff @(posedge clk) begin
        if (wr_m) m_mem[wa] <= bus.s_data;
        if (wr_x) x_mem[wa] <= bus.s_data;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        mv_d    = mv_q;
        start   = 1'b0;
        en      = 1'b0;
        first   = 1'b0;
        case (state_q)
            IDLE: if (hs) begin
                // The starting element may itself be the last one of its phase for tiny shapes.
                start   = 1'b1;
                row_d   = '0;
                state_d = keep_eff ? ((COLS == 1) ? COMPUTE : LOAD_X) : ((MN == 1) ? LOAD_X : LOAD_M);
                cnt_d   = (keep_eff ? (COLS == 1) : (MN == 1)) ? '0 : CW'(1);
                mv_d    = mv_q || (!keep_eff && MN == 1);
            end
            LOAD_M: if (hs) begin
                state_d = (cnt_q == CW'(MN - 1)) ? LOAD_X : LOAD_M;
                cnt_d   = (cnt_q == CW'(MN - 1)) ? '0 : cnt_q + 1'b1;
                mv_d    = mv_q || (cnt_q == CW'(MN - 1));
            end
            LOAD_X: if (hs) begin
                state_d = (cnt_q == CW'(COLS - 1)) ? COMPUTE : LOAD_X;
                cnt_d   = (cnt_q == CW'(COLS - 1)) ? '0 : cnt_q + 1'b1;
            end
            COMPUTE: begin
                en      = 1'b1;
                first   = (cnt_q == '0);
                state_d = (cnt_q == CW'(COLS - 1)) ? DRAIN : COMPUTE;
                cnt_d   = (cnt_q == CW'(COLS - 1)) ? '0 : cnt_q + 1'b1;
            end
            DRAIN: state_d = OUTPUT;
            OUTPUT: if (bus.m_ready) begin
                state_d = (row_q == RW'(ROWS - 1)) ? IDLE : COMPUTE;
                row_d   = (row_q == RW'(ROWS - 1)) ? row_q : row_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
            mv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            mv_q    <= mv_d;
        end
    end

    mvm_mac_lane #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_lane (
        .clk       (clk),
        .reset     (reset),
        .en_i      (en),
        .first_i   (first),
        .clr_ovf_i (start),
        .a_i       (m_mem[m_addr]),
        .b_i       (x_mem[cnt_q]),
        .acc_o     (acc),
        .ovf_o     (ovf)
    );

    assign bus.s_ready = (state_q == IDLE) || (state_q == LOAD_M) || (state_q == LOAD_X);
    assign bus.m_valid = (state_q == OUTPUT);
    assign bus.m_data  = acc;
    assign busy        = (state_q != IDLE);
endmodule
